// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory slave for the memory stage of an RV32IMF pipeline.
//            It accepts one load/store at a time over a valid/ready handshake
//            and decodes the funct3 width/sign. It inserts WAIT_CYCLES wait
//            states, then returns a one-cycle response strobe carrying
//            extended load data and an error flag.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/ready   - request handshake (ready is combinational)
//            req_write         - 1 = store, 0 = load
//            req_addr          - byte address (wraps modulo DEPTH_WORDS*4)
//            req_wdata         - store data (low byte/halfword for SB/SH)
//            req_funct3        - RV32 width/sign code
//            resp_valid        - one-cycle response strobe
//            resp_rdata        - extended load data, 0 for stores/errors
//            resp_err          - illegal funct3 or trapped misalignment
// Options  : DMEM_MISALIGN_TRAP_EN - when defined, a misaligned halfword or
//            word access reports resp_err instead of ignoring the low bits.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        lat_write_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [2:0]  lat_funct3_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic               w_accept;
  logic               w_commit;
  logic               w_use_in;
  logic               w_write;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [2:0]         w_funct3;
  logic               w_illegal;
  logic               w_misalign;
  logic               w_err;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_rword;
  logic [7:0]         w_rbyte;
  logic [15:0]        w_rhalf;
  logic [31:0]        w_load_data;
  logic [3:0]         w_be;
  logic [31:0]        w_wlanes;
  logic               w_we;
  logic               w_unused;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      c_S_IDLE: begin
        if (w_accept) begin
          wait_cnt_d = c_WAIT;
          state_d    = (c_WAIT != 4'd0) ? c_S_WAIT : c_S_RESP;
        end
      end
      c_S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = c_S_RESP;
        end
      end
      c_S_RESP: state_d = c_S_IDLE;
      default:  state_d = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == c_S_IDLE) & ~rst;
    // The commit edge is the one entering RESP; reset suppresses it so an
    // in-flight store is dropped.
    w_commit  = (state_d == c_S_RESP) & (state_q != c_S_RESP) & ~rst;
  end

  assign w_accept = req_valid & req_ready;

  // With zero wait states the commit happens on the accept edge itself, so
  // the live request is used there; otherwise the latched copy.
  assign w_use_in = (state_q == c_S_IDLE);
  assign w_write  = w_use_in ? req_write  : lat_write_q;
  assign w_addr   = w_use_in ? req_addr   : lat_addr_q;
  assign w_wdata  = w_use_in ? req_wdata  : lat_wdata_q;
  assign w_funct3 = w_use_in ? req_funct3 : lat_funct3_q;

  // --------------------------------------------------------------------------
  // Decode and error detection
  // --------------------------------------------------------------------------
  assign w_illegal = (w_funct3 == 3'b011) | (w_funct3[2:1] == 2'b11) |
                     (w_write & w_funct3[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_funct3[1:0] == 2'b01) & w_addr[0]) |
                      ((w_funct3[1:0] == 2'b10) & (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal | w_misalign;
  assign w_idx = w_addr[c_IDX_W+1:2];

  // --------------------------------------------------------------------------
  // Load path
  // --------------------------------------------------------------------------
  assign w_rword = mem_q[w_idx];

  always_comb begin
    w_rbyte = w_rword[7:0];
    case (w_addr[1:0])
      2'd0:    w_rbyte = w_rword[7:0];
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      default: w_rbyte = w_rword[31:24];
    endcase
  end

  assign w_rhalf = w_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load_data = 32'd0;
    if (!w_err) begin
      case (w_funct3)
        3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
        3'b100:  w_load_data = {24'd0, w_rbyte};
        3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
        3'b101:  w_load_data = {16'd0, w_rhalf};
        3'b010:  w_load_data = w_rword;
        default: w_load_data = 32'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Store path: replicate the store data across lanes, then enable lanes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_wdata;
    case (w_funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
      end
      default: begin
        w_be     = 4'b0000;
        w_wlanes = w_wdata;
      end
    endcase
  end

  assign w_we = w_commit & w_write & ~w_err;

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write_q  <= 1'b0;
      lat_addr_q   <= 32'd0;
      lat_wdata_q  <= 32'd0;
      lat_funct3_q <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      if (w_accept) begin
        lat_write_q  <= req_write;
        lat_addr_q   <= req_addr;
        lat_wdata_q  <= req_wdata;
        lat_funct3_q <= req_funct3;
      end
      // Data is captured at the commit edge; the strobe follows the RESP
      // cycle and the captured data holds until the next commit.
      resp_valid_q <= (state_q == c_S_RESP);
      if (w_commit) begin
        resp_rdata_q <= w_write ? 32'd0 : w_load_data;
        resp_err_q   <= w_err;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Address bits above the array index are ignored (wrap-around).
  assign w_unused = ^w_addr[31:c_IDX_W+2];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Directed cases plus
//            randomized loads/stores compared against a byte-level model.
//            A second instance with zero wait states and a small array
//            exercises back-to-back throughput and address wrap.
// Options  : honours DMEM_MISALIGN_TRAP_EN for misaligned expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        b_valid, b_ready, b_write;
  logic [31:0] b_addr, b_wdata;
  logic [2:0]  b_funct3;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_funct3(b_funct3),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: little-endian, aligned-down base for H/W.
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int ba, nb, base;
    logic [31:0] v;
    bit mis;
    ba  = int'(a & 32'(BYTES - 1));
    er  = (f3 == 3'b011) || (f3 >= 3'b110) || (wr && f3[2]);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`endif
    er = er || mis;
    rd = 32'd0;
    if (!er) begin
      nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      base = ba & ~(nb - 1);
      if (wr) begin
        for (int i = 0; i < nb; i++) mem_m[base + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++)
          v[8*i +: 8] = mem_m.exists(base + i) ? mem_m[base + i] : 8'hxx;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        rd = v;
      end
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int n;
    @(negedge clk);
    chk("one_shot", {31'b0, resp_valid}, 32'd0);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    chk("ready_busy", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 1);
    chk("ready_resp", {31'b0, req_ready}, 32'd1);
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input string tag, output logic [31:0] rd);
    logic [31:0] erd;
    bit eer, er;
    model(wr, a, d, f3, erd, eer);
    do_req(wr, a, d, f3, rd, er);
    chk({tag, "_rd"}, rd, erd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, eer});
  endtask

  logic [2:0] f3_tbl [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                              3'b010, 3'b000, 3'b011, 3'b110, 3'b111};

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_funct3 = 3'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'b0, req_ready}, 32'd1);
    chk("rel_valid", {31'b0, resp_valid}, 32'd0);

    // Directed byte/halfword/word cases
    run(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "sw10", r);
    run(1'b1, 32'h11, 32'h00000080, 3'b000, "sb11", r);
    run(1'b0, 32'h11, 32'h0, 3'b000, "lb11", r);   chk("lb11_c", r, 32'hFFFFFF80);
    run(1'b0, 32'h11, 32'h0, 3'b100, "lbu11", r);  chk("lbu11_c", r, 32'h00000080);
    run(1'b0, 32'h10, 32'h0, 3'b010, "lw10", r);   chk("lw10_c", r, 32'hDEAD80EF);
    run(1'b1, 32'h20, 32'h0BADF00D, 3'b010, "sw20", r);
    run(1'b1, 32'h22, 32'h00008001, 3'b001, "sh22", r);
    run(1'b0, 32'h22, 32'h0, 3'b001, "lh22", r);   chk("lh22_c", r, 32'hFFFF8001);
    run(1'b0, 32'h22, 32'h0, 3'b101, "lhu22", r);  chk("lhu22_c", r, 32'h00008001);
    run(1'b0, 32'h20, 32'h0, 3'b010, "lw20", r);   chk("lw20_c", r, 32'h8001F00D);

    // Illegal funct3 on load and store; memory must be untouched
    run(1'b0, 32'h10, 32'h0, 3'b011, "ill_ld", r);      chk("ill_ld_c", r, 32'd0);
    run(1'b1, 32'h10, 32'h0, 3'b100, "ill_st", r);      chk("ill_st_c", r, 32'd0);
    run(1'b0, 32'h10, 32'h0, 3'b010, "lw10_post", r);   chk("lw10_post_c", r, 32'hDEAD80EF);

    // Misaligned word and wrapped address
    run(1'b0, 32'h13, 32'h0, 3'b010, "lw13", r);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw13_c", r, 32'd0);
`else
    chk("lw13_c", r, 32'hDEAD80EF);
`endif
    run(1'b0, 32'h10 + 32'(BYTES * 3), 32'h0, 3'b010, "lw_wrap", r);
    chk("lw_wrap_c", r, 32'hDEAD80EF);

    // Reset in the first wait cycle of a store discards it
    run(1'b1, 32'h40, 32'hCAFEF00D, 3'b010, "sw40", r);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_in_rst", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_post_rst", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    run(1'b0, 32'h40, 32'h0, 3'b010, "lw40", r);  chk("lw40_c", r, 32'hCAFEF00D);

    // Randomized traffic over a pre-initialized region
    for (int i = 0; i < 16; i++)
      run(1'b1, 32'h100 + 32'(4 * i), $urandom, 3'b010, "init", r);
    for (int i = 0; i < 80; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * BYTES);
      run(1'($urandom_range(0, 1)), a, $urandom, f3_tbl[$urandom_range(0, 9)], "rnd", r);
    end

    // Zero-wait instance: store then back-to-back wrapped loads
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h4; b_wdata = 32'hA5A50F0F; b_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    b_write = 1'b0; b_addr = 32'h44; b_wdata = 32'h0;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid", {31'b0, b_resp_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("b2b_st_rd", b_resp_rdata, 32'd0);
        chk("b2b_st_err", {31'b0, b_resp_err}, 32'd0);
      end else if (k >= 3 && (k % 2 == 1)) begin
        chk("b2b_ld_rd", b_resp_rdata, 32'hA5A50F0F);
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32IMF pipeline's memory stage. It accepts one load or store request at a time over a valid/ready handshake and decodes the RV32 funct3 width and sign. It inserts a parameterised number of wait states and returns a single-cycle response with sign- or zero-extended read data. It replaces a zero-latency array with a slave that can model real memory latency, and it is the target for stall generation in the pipeline.

## Interface
Parameters:
- DEPTH_WORDS, 1024 — number of 32-bit words; power of two; address index is addr[log2(DEPTH_WORDS)+1:2].
- WAIT_CYCLES, 2 — wait states between accept and response; 0 to 15 legal.

Ports:
- clk  in  1  — single clock; all state changes on its rising edge.
- rst  in  1  — reset, synchronous, active-high.
- req_valid  in  1  — request present.
- req_ready  out  1  — responder can accept a request.
- req_write  in  1  — 1 = store, 0 = load.
- req_addr  in  32  — byte address.
- req_wdata  in  32  — store data; the low byte or halfword is used for SB and SH.
- req_funct3  in  3  — access width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only).
- resp_valid  out  1  — response strobe, one cycle wide.
- resp_rdata  out  32  — extended load data; 0 for stores and for errors.
- resp_err  out  1  — illegal funct3, or misaligned access when trapping is enabled.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, addr, wdata and funct3, and load wait_cnt = WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
- WAIT:
  - wait_cnt decrements once per cycle.
  - When wait_cnt reaches 1, the next edge goes to RESP.
- Commit edge (the transition into RESP):
  - A store writes memory using byte enables: SB writes lane addr[1:0], SH writes lanes {addr[1],0} and {addr[1],1}, SW writes all four lanes.
  - A load registers its extended data into resp_rdata: LB and LH sign-extend, LBU and LHU zero-extend.
- RESP:
  - resp_valid = 1 for exactly one cycle; the requester has no backpressure.
  - Next state is always IDLE.
- Illegal funct3 (011, 110, 111, or store with 100/101):
  - resp_err = 1, resp_rdata = 0, no memory write.
  - Timing is the same as a normal access.
- Addresses beyond the array wrap modulo DEPTH_WORDS*4; this is not an error.
- Memory contents are not reset and are undefined until first written.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, wait_cnt 0.
- req_ready is combinational and equals (state==IDLE) & ~rst; it is 0 while rst is asserted.
- Handshake: accept at edge N when req_valid & req_ready. resp_valid is high in the cycle after edge N+WAIT_CYCLES+1.
- req_ready is 0 from the cycle after accept until the cycle after RESP.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- Request inputs are ignored outside IDLE, and the latched copies are used. req_valid held high across RESP is accepted again in the next IDLE cycle.
- Reset mid-operation:
  - Returns to IDLE at the next edge and clears the outputs.
  - A store whose commit edge has not occurred is discarded.
  - A store committed before reset persists.
- Load after store to the same address: the load returns the new data, because the store commits before the load is accepted.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, sets resp_err = 1.
  - resp_rdata = 0 and there is no write.
  - Timing is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Misaligned low address bits are ignored: H uses addr[1], W uses the word index.
  - The access completes normally with resp_err = 0.

## Test plan
- Reset, then release → req_ready=1 and resp_valid=0. With WAIT_CYCLES=2, SW 0xDEADBEEF to 0x10 accepted at edge 0 → resp_valid high only after edge 3, resp_err=0.
- SB 0x80 to 0x11, then LB 0x11 → resp_rdata=0xFFFFFF80. LBU 0x11 → 0x00000080. LW 0x10 → 0xDEAD80EF.
- SH 0x8001 to 0x22, then LH 0x22 → 0xFFFF8001. LHU 0x22 → 0x00008001. LW 0x20 → upper half 0x8001, lower half unchanged.
- funct3=011 load, and a store with funct3=100 → resp_err=1, resp_rdata=0, memory unchanged on readback.
- LW to 0x13:
  - With DMEM_MISALIGN_TRAP_EN → resp_err=1.
  - Without it → returns the word at 0x10 and resp_err=0.
- rst pulsed in the first WAIT cycle of SW 0x12345678 to 0x40 → no resp_valid, req_ready=1 after rst drops, LW 0x40 returns the prior contents. Also with WAIT_CYCLES=0, back-to-back requests → resp_valid every 2nd cycle.
